// File: rtl/spi_cmd_seq_pkg.sv
// Shared types and constants for the SPI command sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package spi_cmd_seq_pkg;

    // Sequencer states, in frame order.
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PUSH,
        ST_START,
        ST_WAIT_BUSY,
        ST_WAIT_DONE,
        ST_DRAIN,
        ST_RESP
    } seq_state_t;

    // Default header bytes for write and read frames.
    localparam logic [7:0] DEF_WR_CMD = 8'h02;
    localparam logic [7:0] DEF_RD_CMD = 8'h03;

endpackage

// File: rtl/spi_seq_timer.sv
// Per-state cycle counter that flags a stalled wait state.
// Latency: expired rises combinationally on the TIMEOUT-th enabled cycle after clear.
// Backpressure: none; counts only while enable is high, clear wins over enable.
module spi_seq_timer #(
    parameter int TIMEOUT = 1024
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] cnt;

    // Count enabled cycles since the last clear; stop once expired.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (enable && !expired) begin
            cnt <= cnt + CW'(1);
        end
    end

    // The current cycle is the TIMEOUT-th one spent in the state.
    assign expired = enable && (cnt == CW'(TIMEOUT - 1));

endmodule

// File: rtl/spi_cmd_seq.sv
// Turns host register read/write requests into SPI frames: header, address, payload, then RX drain.
// Latency: first TX byte the cycle after acceptance, one byte per cycle, start strobe one cycle after the last byte.
// Backpressure: TX full stalls the push; RX empty stalls the drain; waits time out. SPI_CMD_SEQ_INIT_EN adds a boot-time write.
module spi_cmd_seq
    import spi_cmd_seq_pkg::*;
#(
    parameter int              DATA       = 8,
    parameter int              ADDR_BYTES = 2,
    parameter int              NBYTES     = 2,
    parameter logic [DATA-1:0] WR_CMD     = DATA'(DEF_WR_CMD),
    parameter logic [DATA-1:0] RD_CMD     = DATA'(DEF_RD_CMD),
    parameter int              TIMEOUT    = 1024
`ifdef SPI_CMD_SEQ_INIT_EN
    ,
    parameter logic [ADDR_BYTES*DATA-1:0] INIT_ADDR = (ADDR_BYTES*DATA)'(16'h0019),
    parameter logic [NBYTES*DATA-1:0]     INIT_DATA = (NBYTES*DATA)'(16'h04FF)
`endif
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       req_valid,
    output logic                       req_ready,
    input  logic                       req_op,
    input  logic [ADDR_BYTES*DATA-1:0] req_addr,
    input  logic [NBYTES*DATA-1:0]     req_data,
    output logic                       rsp_valid,
    output logic [NBYTES*DATA-1:0]     rsp_data,
    output logic                       rsp_err,
    output logic [15:0]                len,
    output logic                       op,
    output logic                       work,
    input  logic                       busy,
    output logic [DATA-1:0]            wdata,
    output logic                       wr,
    input  logic                       full,
    input  logic [DATA-1:0]            rdata,
    output logic                       rd,
    input  logic                       empty
);

    localparam int          HDR_BYTES   = 1 + ADDR_BYTES;
    localparam int          FRAME_BYTES = HDR_BYTES + NBYTES;
    localparam int          FRAME_W     = FRAME_BYTES * DATA;
    localparam int          RSP_W       = NBYTES * DATA;
    localparam int          CNT_W       = $clog2(FRAME_BYTES + 1);
    localparam logic [15:0] FRAME_LEN   = 16'(FRAME_W);

    seq_state_t         state, state_nxt;
    logic               op_q;
    logic [FRAME_W-1:0] tx_sr;
    logic [RSP_W-1:0]   rx_q;
    logic [RSP_W-1:0]   rx_nxt;
    logic               err_q;
    logic [CNT_W-1:0]   byte_cnt;
    logic [CNT_W-1:0]   push_last;
    logic               to_hit;
    logic               tmr_clear;
    logic               tmr_en;
    logic               tmr_expired;
    logic               load;
    logic               ld_op;
    logic [FRAME_W-1:0] ld_frame;
    logic [FRAME_W-1:0] req_frame;
    logic               init_go;
    logic               init_run;

    assign req_frame = {(req_op ? WR_CMD : RD_CMD), req_addr, req_data};

`ifdef SPI_CMD_SEQ_INIT_EN
    logic init_pend;

    // One boot-time write is pending from reset until it is loaded; its response is swallowed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            init_pend <= 1'b1;
            init_run  <= 1'b0;
        end else if (load) begin
            init_pend <= 1'b0;
            init_run  <= init_pend;
        end
    end

    assign init_go  = init_pend;
    assign ld_op    = init_pend | req_op;
    assign ld_frame = init_pend ? {WR_CMD, INIT_ADDR, INIT_DATA} : req_frame;
`else
    assign init_go  = 1'b0;
    assign init_run = 1'b0;
    assign ld_op    = req_op;
    assign ld_frame = req_frame;
`endif

    // Reads stop pushing after the address; the SPI controller clocks dummy bytes for the payload.
    assign push_last = op_q ? CNT_W'(FRAME_BYTES - 1) : CNT_W'(HDR_BYTES - 1);

    // Keep the most recent NBYTES popped bytes, newest in the LSBs.
    generate
        if (NBYTES == 1) begin : g_rx_one
            assign rx_nxt = rdata;
        end else begin : g_rx_many
            assign rx_nxt = {rx_q[RSP_W-DATA-1:0], rdata};
        end
    endgenerate

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; to_hit marks an exit to RESP caused by a stalled wait.
    always_comb begin
        state_nxt = state;
        to_hit    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!busy && (init_go || req_valid)) begin
                    state_nxt = ST_PUSH;
                end
            end
            ST_PUSH: begin
                if (!full && (byte_cnt == push_last)) begin
                    state_nxt = ST_START;
                end
            end
            ST_START: begin
                state_nxt = ST_WAIT_BUSY;
            end
            ST_WAIT_BUSY: begin
                if (busy) begin
                    state_nxt = ST_WAIT_DONE;
                end else if (tmr_expired) begin
                    state_nxt = ST_RESP;
                    to_hit    = 1'b1;
                end
            end
            ST_WAIT_DONE: begin
                if (!busy) begin
                    state_nxt = ST_DRAIN;
                end else if (tmr_expired) begin
                    state_nxt = ST_RESP;
                    to_hit    = 1'b1;
                end
            end
            ST_DRAIN: begin
                if (!empty && (byte_cnt == CNT_W'(FRAME_BYTES - 1))) begin
                    state_nxt = ST_RESP;
                end else if (tmr_expired) begin
                    state_nxt = ST_RESP;
                    to_hit    = 1'b1;
                end
            end
            ST_RESP: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    assign load = (state == ST_IDLE) && (state_nxt == ST_PUSH);

    // Byte counter for push and drain, restarted on every state change.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            byte_cnt <= '0;
        end else if (state != state_nxt) begin
            byte_cnt <= '0;
        end else if (wr || rd) begin
            byte_cnt <= byte_cnt + CNT_W'(1);
        end
    end

    // Latch the request frame, shift TX bytes out MSB-first, assemble read data, record timeouts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q  <= 1'b0;
            tx_sr <= '0;
            rx_q  <= '0;
            err_q <= 1'b0;
        end else if (load) begin
            op_q  <= ld_op;
            tx_sr <= ld_frame;
            rx_q  <= '0;
            err_q <= 1'b0;
        end else begin
            if (wr) begin
                tx_sr <= {tx_sr[FRAME_W-DATA-1:0], {DATA{1'b0}}};
            end
            if (rd && !op_q) begin
                rx_q <= rx_nxt;
            end
            if (to_hit) begin
                rx_q  <= '0;
                err_q <= 1'b1;
            end
        end
    end

    assign tmr_clear = (state != state_nxt);
    assign tmr_en    = (state == ST_WAIT_BUSY) || (state == ST_WAIT_DONE) || (state == ST_DRAIN);

    spi_seq_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (tmr_clear),
        .enable  (tmr_en),
        .expired (tmr_expired)
    );

    // Requests are refused while reset is asserted so the host never sees a phantom accept.
    assign req_ready = rst_n && (state == ST_IDLE) && !busy && !init_go;
    assign wr        = (state == ST_PUSH) && !full;
    assign wdata     = (state == ST_PUSH) ? tx_sr[FRAME_W-1 -: DATA] : '0;
    assign work      = (state == ST_START);
    assign op        = (state == ST_START) ? op_q : 1'b0;
    assign len       = (state == ST_START) ? FRAME_LEN : '0;
    assign rd        = (state == ST_DRAIN) && !empty;
    assign rsp_valid = (state == ST_RESP) && !init_run;
    assign rsp_err   = rsp_valid && err_q;
    assign rsp_data  = rsp_valid ? rx_q : '0;

endmodule

// File: tb/tb_spi_cmd_seq.sv
// Directed bench for spi_cmd_seq: writes, reads, TX stall, timeouts, mid-frame reset, optional boot write.
// Latency: checks cycle-exact byte, start and response timing against hand-derived values.
// Backpressure: drives full/empty/busy directly in place of the SPI controller and FIFOs.
module tb_spi_cmd_seq;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_op;
    logic [15:0] req_addr;
    logic [15:0] req_data;
    logic        rsp_valid;
    logic [15:0] rsp_data;
    logic        rsp_err;
    logic [15:0] len;
    logic        op;
    logic        work;
    logic        busy;
    logic [7:0]  wdata;
    logic        wr;
    logic        full;
    logic [7:0]  rdata;
    logic        rd;
    logic        empty;

    int checks   = 0;
    int failures = 0;

    spi_cmd_seq #(
        .TIMEOUT (16)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_addr  (req_addr),
        .req_data  (req_data),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .rsp_err   (rsp_err),
        .len       (len),
        .op        (op),
        .work      (work),
        .busy      (busy),
        .wdata     (wdata),
        .wr        (wr),
        .full      (full),
        .rdata     (rdata),
        .rd        (rd),
        .empty     (empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard stop in case a wait loop is broken.
    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Inputs change just after the rising edge; outputs are sampled on the falling edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    function automatic logic [46:0] all_outs();
        return {req_ready, wr, wdata, work, op, len, rsp_valid, rsp_err, rsp_data, rd};
    endfunction

    task automatic accept(input logic o, input logic [15:0] a, input logic [15:0] d);
        tick();
        req_valid = 1'b1;
        req_op    = o;
        req_addr  = a;
        req_data  = d;
        settle();
        chk("req_ready_idle", req_ready, 1);
        tick();
        req_valid = 1'b0;
        req_addr  = 16'hDEAD;
        req_data  = 16'hBEEF;
    endtask

    // Expect n consecutive TX writes, bytes taken MSB-first from exp.
    task automatic push_bytes(input logic [39:0] exp, input int n);
        for (int i = 0; i < n; i++) begin
            settle();
            chk("push_byte", {req_ready, wr, wdata}, {2'b01, exp[39-8*i -: 8]});
            tick();
        end
    endtask

    task automatic check_start(input logic o);
        settle();
        chk("start", {work, op, len}, {1'b1, o, 16'd40});
        tick();
        settle();
        chk("work_low", {work, op, len}, 18'd0);
    endtask

    task automatic handshake();
        busy = 1'b1;
        tick();
        tick();
        busy = 1'b0;
        tick();
    endtask

    // Serve the RX FIFO: avail bytes from rx, one empty bubble at cycle 'bubble'.
    task automatic drain(input logic [39:0] rx, input int avail, input int bubble,
                         output int pops, output int ncyc, output int rd_bad);
        logic was_rd;
        pops   = 0;
        ncyc   = 0;
        rd_bad = 0;
        while (rsp_valid !== 1'b1 && ncyc < 40) begin
            empty = (ncyc == bubble) || (pops >= avail);
            rdata = (pops < 5) ? rx[39-8*pops -: 8] : 8'h00;
            settle();
            if (rsp_valid === 1'b1) break;
            if (rd !== !empty) rd_bad++;
            was_rd = rd;
            tick();
            if (was_rd) pops++;
            ncyc++;
        end
        empty = 1'b1;
    endtask

    task automatic resp_then_idle();
        tick();
        settle();
        chk("back_to_idle", {rsp_valid, req_ready}, 2'b01);
    endtask

    int pops, ncyc, rd_bad, n, seen;

    initial begin
        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_op    = 1'b0;
        req_addr  = '0;
        req_data  = '0;
        busy      = 1'b0;
        full      = 1'b0;
        rdata     = '0;
        empty     = 1'b1;

        // Reset state: everything low, including req_ready.
        tick();
        tick();
        settle();
        chk("reset_outs", all_outs(), 47'd0);
        tick();
        rst_n = 1'b1;

`ifdef SPI_CMD_SEQ_INIT_EN
        // Boot write runs on its own, hidden from the host.
        settle();
        chk("init_rdy_low", req_ready, 0);
        tick();
        push_bytes(40'h02_00_19_04_FF, 5);
        check_start(1'b1);
        handshake();
        empty = 1'b0;
        n     = 0;
        seen  = 0;
        while (req_ready !== 1'b1 && n < 40) begin
            settle();
            if (rsp_valid === 1'b1) seen++;
            tick();
            n++;
        end
        empty = 1'b1;
        chk("init_no_rsp", seen, 0);
        settle();
        chk("init_then_ready", req_ready, 1);
`else
        settle();
        chk("ready_after_rst", req_ready, 1);
`endif

        // Write 0x0019 <= 0x04FF: bytes on cycles 1..5, start on cycle 6.
        accept(1'b1, 16'h0019, 16'h04FF);
        push_bytes(40'h02_00_19_04_FF, 5);
        check_start(1'b1);
        handshake();
        drain(40'h11_22_33_44_55, 5, -1, pops, ncyc, rd_bad);
        chk("wr_pops", pops, 5);
        chk("wr_drain_cycles", ncyc, 5);
        chk("wr_rsp", {rsp_valid, rsp_err, rsp_data}, {2'b10, 16'h0000});
        resp_then_idle();

        // Read 0x0019 with RX AA,BB,CC,12,34 and one empty bubble.
        accept(1'b0, 16'h0019, 16'h5555);
        push_bytes(40'h03_00_19_00_00, 3);
        check_start(1'b0);
        handshake();
        drain(40'hAA_BB_CC_12_34, 5, 2, pops, ncyc, rd_bad);
        chk("rd_pops", pops, 5);
        chk("rd_only_when_nonempty", rd_bad, 0);
        chk("rd_drain_cycles", ncyc, 6);
        chk("rd_rsp", {rsp_valid, rsp_err, rsp_data}, {2'b10, 16'h1234});
        resp_then_idle();

        // TX full for three cycles after the second byte.
        accept(1'b1, 16'h0019, 16'h04FF);
        push_bytes(40'h02_00_00_00_00, 2);
        full = 1'b1;
        for (int i = 0; i < 3; i++) begin
            settle();
            chk("stall_hold", {wr, wdata}, {1'b0, 8'h19});
            tick();
        end
        full = 1'b0;
        push_bytes(40'h19_04_FF_00_00, 3);
        check_start(1'b1);
        handshake();
        drain(40'h01_02_03_04_05, 5, -1, pops, ncyc, rd_bad);
        chk("stall_rsp", {rsp_valid, rsp_err, pops[3:0]}, {2'b10, 4'd5});
        resp_then_idle();

        // busy never rises: START, then 16 wait cycles, then RESP with error.
        accept(1'b1, 16'h0019, 16'h04FF);
        push_bytes(40'h02_00_19_04_FF, 5);
        check_start(1'b1);
        n = 1;
        while (rsp_valid !== 1'b1 && n < 40) begin
            tick();
            settle();
            n++;
        end
        chk("to_busy_latency", n, 17);
        chk("to_busy_rsp", {rsp_valid, rsp_err, rsp_data}, {2'b11, 16'h0000});
        resp_then_idle();

        // Read whose RX data stops after two bytes: drain times out, data cleared.
        accept(1'b0, 16'h0019, 16'h0000);
        push_bytes(40'h03_00_19_00_00, 3);
        check_start(1'b0);
        handshake();
        drain(40'h12_34_00_00_00, 2, -1, pops, ncyc, rd_bad);
        chk("to_drain_pops", pops, 2);
        chk("to_drain_cycles", ncyc, 16);
        chk("to_drain_rsp", {rsp_valid, rsp_err, rsp_data}, {2'b11, 16'h0000});
        resp_then_idle();

        // Reset while the controller is busy: outputs drop at once, next frame is clean.
        accept(1'b1, 16'h0019, 16'h04FF);
        push_bytes(40'h02_00_19_04_FF, 5);
        check_start(1'b1);
        busy = 1'b1;
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        chk("midframe_reset_outs", all_outs(), 47'd0);
        busy = 1'b0;
        tick();
        rst_n = 1'b1;
`ifdef SPI_CMD_SEQ_INIT_EN
        tick();
        push_bytes(40'h02_00_19_04_FF, 5);
        check_start(1'b1);
        handshake();
        empty = 1'b0;
        n     = 0;
        while (req_ready !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        empty = 1'b1;
`endif
        settle();
        chk("ready_after_midreset", req_ready, 1);
        accept(1'b0, 16'h00A5, 16'h0000);
        push_bytes(40'h03_00_A5_00_00, 3);
        check_start(1'b0);
        handshake();
        drain(40'h01_02_03_BE_EF, 5, -1, pops, ncyc, rd_bad);
        chk("post_reset_rsp", {rsp_valid, rsp_err, rsp_data}, {2'b10, 16'hBEEF});
        resp_then_idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
